serial_adder_sched: RTL

Round-robin scheduler that shares one `serial_adder` instance (16-bit, start/done handshake) among NREQ requesters. It accepts operand pairs from requesters and launches one addition at a time on the adder. It returns the registered sum with a one-cycle acknowledge to the granted requester, and recovers the adder through a watchdog if `done` never arrives. It sits between the requesting datapath units and the single `serial_adder`.

---
 rtl/serial_sched_pkg.sv | 16 +
 rtl/serial_adder_sched_rr_arbiter.sv | 34 +++
 rtl/serial_adder_sched.sv | 136 +++++++++++++
 3 files changed

// File: rtl/serial_sched_pkg.sv
// Shared types and default sizing for the serial adder scheduler.
package serial_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } sched_state_t;

    localparam int DEF_W       = 16;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/serial_adder_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last+1 upward (mod NREQ)
// and returns the first requester found as a one-hot grant plus its index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] idx
);

    logic            found_s;
    logic [IDXW-1:0] cand_s;

    // Rotating priority search; the previous winner is examined last.
    always_comb begin
        grant   = '0;
        idx     = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = IDXW'((int'(last) + k) % NREQ);
            if (!found_s && req[cand_s]) begin
                found_s       = 1'b1;
                grant[cand_s] = 1'b1;
                idx           = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/serial_adder_sched.sv
// Round-robin scheduler sharing one serial_adder among NREQ requesters.
// Every output is driven straight from a flop; a watchdog recovers the adder
// if done never arrives.
module serial_adder_sched
    import serial_sched_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int W       = DEF_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   ack,
    output logic [W-1:0]      sum_out,
    output logic              err,
    output logic              busy,
    output logic              adder_start,
    output logic [W-1:0]      adder_a,
    output logic [W-1:0]      adder_b,
    output logic              adder_reset,
    input  logic [W-1:0]      adder_sum,
    input  logic              adder_done
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW  = $clog2(TIMEOUT + 1);

    sched_state_t    state_r;
    logic [IDXW-1:0] last_r;
    logic [NREQ-1:0] grant_r;
    logic [WDW-1:0]  wdog_r;
    logic [NREQ-1:0] ack_r;
    logic [W-1:0]    sum_out_r;
    logic            err_r;
    logic            busy_r;
    logic            start_r;
    logic [W-1:0]    adder_a_r;
    logic [W-1:0]    adder_b_r;
    logic            adder_reset_r;

    logic [NREQ-1:0] grant_s;
    logic [IDXW-1:0] idx_s;

    rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
        .req   (req),
        .last  (last_r),
        .grant (grant_s),
        .idx   (idx_s)
    );

    // Scheduler FSM; outputs are set on the transition into the state that shows them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            last_r        <= IDXW'(NREQ - 1);
            grant_r       <= '0;
            wdog_r        <= '0;
            ack_r         <= '0;
            sum_out_r     <= '0;
            err_r         <= 1'b0;
            busy_r        <= 1'b0;
            start_r       <= 1'b0;
            adder_a_r     <= '0;
            adder_b_r     <= '0;
            adder_reset_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|req) begin
                        grant_r   <= grant_s;
                        last_r    <= idx_s;
                        adder_a_r <= a_in[idx_s*W +: W];
                        adder_b_r <= b_in[idx_s*W +: W];
                        start_r   <= 1'b1;
                        busy_r    <= 1'b1;
                        state_r   <= LAUNCH;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                LAUNCH: begin
                    start_r <= 1'b0;
                    wdog_r  <= '0;
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (adder_done) begin
                        sum_out_r <= adder_sum;
                        err_r     <= 1'b0;
                        ack_r     <= grant_r;
                        state_r   <= RESP;
                    end else if (wdog_r == WDW'(TIMEOUT - 1)) begin
                        // Adder hung: report error with a zero sum and kick its reset.
                        sum_out_r     <= '0;
                        err_r         <= 1'b1;
                        ack_r         <= grant_r;
                        adder_reset_r <= 1'b1;
                        state_r       <= RESP;
                    end else begin
                        wdog_r <= wdog_r + WDW'(1);
                    end
                end
                RESP: begin
                    ack_r         <= '0;
                    sum_out_r     <= '0;
                    err_r         <= 1'b0;
                    adder_reset_r <= 1'b0;
                    busy_r        <= 1'b0;
                    state_r       <= IDLE;
                end
                default: begin
                    ack_r         <= '0;
                    sum_out_r     <= '0;
                    err_r         <= 1'b0;
                    adder_reset_r <= 1'b0;
                    start_r       <= 1'b0;
                    busy_r        <= 1'b0;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

    assign ack         = ack_r;
    assign sum_out     = sum_out_r;
    assign err         = err_r;
    assign busy        = busy_r;
    assign adder_start = start_r;
    assign adder_a     = adder_a_r;
    assign adder_b     = adder_b_r;
    assign adder_reset = adder_reset_r;

endmodule
